// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART transmit arbiter.
//   UART_FRAME_BITS : bit periods per frame (start + 8 data + stop)
//   arb_state_t     : arbiter FSM state encoding
package uart_pkg;

  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   valid [N]   : request vector
//   ptr   [IW]  : index of the last winner; search starts at ptr+1 and wraps
//   grant [N]   : one-hot winner, all-zero when nothing is valid
//   idx   [IW]  : index of the winner (0 when nothing is valid)
//   any         : at least one request is valid
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk the N positions after ptr; the first valid one wins. ptr itself is
  // visited last, so the previous winner has lowest priority.
  always_comb begin
    logic [IW-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte producers.
//   clk, rst_n   : clock, synchronous active-low reset
//   req_valid_i  : per-requester byte available
//   req_data_i   : per-requester byte
//   req_ready_o  : one-hot accept (combinational, IDLE only)
//   tx_send_o    : send strobe to uart_tx, SEND_CYCLES cycles per frame
//   tx_data_o    : byte to uart_tx, held until the next transfer
//   busy_o       : frame in flight (SEND or WAIT)
//   grant_id_o   : index of the last granted requester
// uart_tx has no busy flag, so the frame time is counted here: after a
// transfer the arbiter stays busy for FRAME_CLKS cycles, then re-arbitrates.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int CLKS_PER_BIT = 868,
  parameter  int SEND_CYCLES  = 1,
  parameter  int GAP_CLKS     = 0,
  localparam int IW           = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ-1:0][7:0] req_data_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    tx_send_o,
  output logic [7:0]              tx_data_o,
  output logic                    busy_o,
  output logic [IW-1:0]           grant_id_o
);

  localparam int FRAME_CLKS = CLKS_PER_BIT * UART_FRAME_BITS + GAP_CLKS;
  localparam int CW         = $clog2(FRAME_CLKS + 1);
  localparam logic [CW-1:0] FRAME_TC = CW'(FRAME_CLKS);
  localparam logic [CW-1:0] SEND_TC  = CW'(SEND_CYCLES);

  arb_state_t           state;
  logic [CW-1:0]        cnt;   // 1-based index of the current busy cycle
  logic [IW-1:0]        ptr;
  logic [NUM_REQ-1:0]   pick;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .valid (req_valid_i),
    .ptr   (ptr),
    .grant (pick),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Gated by rst_n so a producer never sees a handshake the reset discards.
  assign req_ready_o = (state == ARB_IDLE && rst_n) ? pick : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      cnt        <= '0;
      ptr        <= IW'(NUM_REQ - 1);
      tx_send_o  <= 1'b0;
      tx_data_o  <= 8'h00;
      busy_o     <= 1'b0;
      grant_id_o <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            state      <= ARB_SEND;
            cnt        <= CW'(1);
            tx_send_o  <= 1'b1;
            busy_o     <= 1'b1;
            tx_data_o  <= req_data_i[pick_idx];
            grant_id_o <= pick_idx;
            ptr        <= pick_idx;
          end
        end
        ARB_SEND, ARB_WAIT: begin
          if (cnt == FRAME_TC) begin
            state     <= ARB_IDLE;
            cnt       <= '0;
            tx_send_o <= 1'b0;
            busy_o    <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
            // strobe covers busy cycles 1..SEND_CYCLES
            if (cnt < SEND_TC) begin
              state     <= ARB_SEND;
              tx_send_o <= 1'b1;
            end else begin
              state     <= ARB_WAIT;
              tx_send_o <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ARB_IDLE;
          tx_send_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int CPB   = 4;
  localparam int SC    = 1;
  localparam int GAP   = 2;
  localparam int FRAME = CPB * 10 + GAP;  // 42

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N-1:0]       valid = '0;
  logic [N-1:0][7:0]  data = '0;
  logic [N-1:0]       ready;
  logic               send;
  logic [7:0]         txd;
  logic               busy;
  logic [1:0]         gid;

  logic [N-1:0]       v2 = '0;
  logic [N-1:0][7:0]  d2 = '0;
  logic [N-1:0]       r2;
  logic               s2;
  logic [7:0]         t2;
  logic               b2;
  logic [1:0]         g2;

  int  nchk = 0;
  int  nfail = 0;
  bit  mon_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .CLKS_PER_BIT(CPB), .SEND_CYCLES(SC), .GAP_CLKS(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(valid), .req_data_i(data),
    .req_ready_o(ready), .tx_send_o(send), .tx_data_o(txd), .busy_o(busy), .grant_id_o(gid));

  uart_tx_arbiter #(.NUM_REQ(N), .CLKS_PER_BIT(CPB), .SEND_CYCLES(10), .GAP_CLKS(GAP)) dut10 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(v2), .req_data_i(d2),
    .req_ready_o(r2), .tx_send_o(s2), .tx_data_o(t2), .busy_o(b2), .grant_id_o(g2));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy && !b2) begin ok = 1'b1; break; end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
    step();
  endtask

  // Reference model: the arbiter is busy for FRAME cycles after each transfer
  // timestamp; when free, the winner is the first valid requester after the
  // last winner. Outputs are derived from the age of the last transfer.
  int          cyc = 0;
  int          last_x = 0;
  bit          have_x = 1'b0;
  logic [7:0]  m_data = 8'h00;
  logic [1:0]  m_id = 2'd0;
  logic [1:0]  m_ptr = 2'd3;

  always @(negedge clk) begin
    logic [N-1:0] e_rdy;
    int age, widx;
    bit idle;
    if (mon_en) begin
      age   = have_x ? (cyc - last_x) : 0;
      idle  = !have_x || (age > FRAME);
      e_rdy = '0;
      widx  = 0;
      if (idle && rst_n)
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (int'(m_ptr) + k) % N;
          if (e_rdy == '0 && valid[j]) begin e_rdy[j] = 1'b1; widx = j; end
        end
      chk("m_ready", 32'(ready), 32'(e_rdy));
      chk("m_send",  32'(send),  32'(have_x && age >= 1 && age <= SC));
      chk("m_busy",  32'(busy),  32'(have_x && age >= 1 && age <= FRAME));
      chk("m_data",  32'(txd),   32'(m_data));
      chk("m_gid",   32'(gid),   32'(m_id));
      if (!rst_n) begin
        have_x = 1'b0; m_data = 8'h00; m_id = 2'd0; m_ptr = 2'd3;
      end else if (e_rdy != '0) begin
        have_x = 1'b1; last_x = cyc; m_data = data[widx];
        m_id = 2'(widx); m_ptr = 2'(widx);
      end
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nb, ns, n, rises;
    time tprev;
    bit prev;
    logic [7:0] b3 [3];
    b3[0] = 8'h11; b3[1] = 8'h22; b3[2] = 8'h33;

    // Reset state
    @(posedge clk); #1 mon_en = 1'b1;
    @(negedge clk);
    chk("rst_send", 32'(send), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(txd), 32'd0);
    chk("rst_gid",  32'(gid), 32'd0);
    chk("rst_s2",   32'(s2), 32'd0);
    step(2);
    rst_n = 1'b1;

    // 1: single request from requester 2
    valid = 4'b0100; data[2] = 8'h55;
    @(negedge clk);
    chk("t1_ready", 32'(ready), 32'h4);
    step();
    valid = '0;
    @(negedge clk);
    chk("t1_send", 32'(send), 32'd1);
    chk("t1_data", 32'(txd), 32'h55);
    chk("t1_gid",  32'(gid), 32'd2);
    nb = 0; ns = 0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (!busy) break;
      nb++;
      if (send) ns++;
    end
    chk("t1_busy_len", 32'(nb), 32'd42);
    chk("t1_send_len", 32'(ns), 32'd1);
    step();

    // 2: all four valid from reset, grants rotate 0,1,2,3,0
    rst_n = 1'b0; step(2);
    rst_n = 1'b1;
    valid = 4'hF;
    data[0] = 8'hA0; data[1] = 8'hA1; data[2] = 8'hA2; data[3] = 8'hA3;
    n = 0; tprev = 0;
    for (int k = 0; k < 400 && n < 5; k++) begin
      @(negedge clk);
      if (ready != '0) begin
        chk("t2_grant", 32'(ready), 32'd1 << (n % 4));
        if (n > 0) chk("t2_gap", 32'(($time - tprev) / 10), 32'd43);
        tprev = $time;
        n++;
        @(negedge clk);
        chk("t2_gid",  32'(gid), 32'((n - 1) % 4));
        chk("t2_data", 32'(txd), 32'(8'hA0 + 8'((n - 1) % 4)));
      end
    end
    chk("t2_count", 32'(n), 32'd5);
    step();
    valid = '0;
    wait_idle();

    // 3: sole requester 1 holding valid, three bytes back to back
    valid = 4'b0010; data[1] = b3[0];
    n = 0;
    for (int k = 0; k < 400 && n < 3; k++) begin
      @(negedge clk);
      if (ready != '0) begin
        chk("t3_grant", 32'(ready), 32'h2);
        if (n > 0) chk("t3_gap", 32'(($time - tprev) / 10), 32'd43);
        tprev = $time;
        step();
        n++;
        if (n < 3) data[1] = b3[n]; else valid = '0;
        @(negedge clk);
        chk("t3_data", 32'(txd), 32'(b3[n - 1]));
        chk("t3_send", 32'(send), 32'd1);
      end
    end
    chk("t3_count", 32'(n), 32'd3);
    wait_idle();

    // 4: valid[3] pulsed only while busy is never granted
    valid = 4'b0001; data[0] = 8'h77;
    step();
    valid = '0;
    step(5);
    valid = 4'b1000; data[3] = 8'hEE;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_ready", 32'(ready), 32'd0);
      chk("t4_busy", 32'(busy), 32'd1);
    end
    step();
    valid = '0;
    wait_idle();
    ns = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (send) ns++;
    end
    chk("t4_no_frame", 32'(ns), 32'd0);
    step();

    // 5: reset in the middle of WAIT, pending valid[1] after release
    valid = 4'b0001; data[0] = 8'h3C;
    step();
    valid = '0;
    step(20);
    valid = 4'b0010; data[1] = 8'h5A;
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("t5_send",  32'(send), 32'd0);
    chk("t5_busy",  32'(busy), 32'd0);
    chk("t5_data",  32'(txd), 32'd0);
    chk("t5_gid",   32'(gid), 32'd0);
    chk("t5_ready", 32'(ready), 32'd0);
    step(4);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_ready_rel", 32'(ready), 32'h2);
    step();
    valid = '0;
    @(negedge clk);
    chk("t5_send_rel", 32'(send), 32'd1);
    chk("t5_data_rel", 32'(txd), 32'h5A);
    chk("t5_gid_rel",  32'(gid), 32'd1);
    wait_idle();

    // 6: SEND_CYCLES=10 instance, two frames from requester 2
    v2 = 4'b0100; d2[2] = 8'h99;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (r2 != '0) begin n = 1; break; end
    end
    chk("t6_first_grant", 32'(n), 32'd1);
    tprev = $time;
    step();
    @(negedge clk);
    chk("t6_data", 32'(t2), 32'h99);
    chk("t6_gid",  32'(g2), 32'd2);
    nb = 0; ns = 0; rises = 0; prev = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (!b2) break;
      nb++;
      if (s2) ns++;
      if (s2 && !prev) rises++;
      prev = s2;
    end
    chk("t6_send_len", 32'(ns), 32'd10);
    chk("t6_busy_len", 32'(nb), 32'd42);
    chk("t6_one_strobe", 32'(rises), 32'd1);
    chk("t6_regrant", 32'(r2), 32'h4);
    chk("t6_gap", 32'(($time - tprev) / 10), 32'd43);
    step();
    v2 = '0;
    wait_idle();

    // Random traffic against the model, with occasional resets
    for (int k = 0; k < 4000; k++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) valid[i] = ~valid[i];
        if ($urandom_range(0, 1) == 1) data[i] = 8'($urandom);
      end
      step();
    end
    rst_n = 1'b1;
    valid = '0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
